mmio_port_responder: RTL

- Memory-mapped I/O responder on the processor's data-memory bus. It decodes the same Address/WriteData/MemWrite/MemRead signals the data RAM sees, and sits in parallel with the RAM.
- Owns the PortOut register, a synchronized and change-flagged PortIn, and a down-counter timer with a sticky expiry flag.
- The top level muxes this block's ReadData into the load path when Hit=1.

---
 rtl/mmio_port_responder_if.sv | 19 +
 rtl/mmio_port_responder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mmio_port_responder_if.sv
// Data-memory bus as seen by an MMIO responder sitting in parallel with the data RAM.
interface mmio_port_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic        Hit;
  logic [31:0] ReadData;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  Hit, ReadData
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output Hit, ReadData
  );
endinterface

// File: rtl/mmio_port_responder.sv
// MMIO responder: PORT_OUT register, synchronized/change-flagged PORT_IN, and a
// down-counter timer with sticky expiry, decoded from the data-memory bus.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0100,
  parameter int          IN_WIDTH    = 8,
  parameter int          TIMER_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  mmio_port_responder_if.slave bus,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                TimerIrq
);

  localparam logic [2:0] OFF_PORT_OUT = 3'd0;
  localparam logic [2:0] OFF_PORT_IN  = 3'd1;
  localparam logic [2:0] OFF_IN_CHG   = 3'd2;
  localparam logic [2:0] OFF_CTRL     = 3'd3;
  localparam logic [2:0] OFF_LOAD     = 3'd4;
  localparam logic [2:0] OFF_COUNT    = 3'd5;
  localparam logic [2:0] OFF_STATUS   = 3'd6;

  // Count saturates at zero rather than wrapping.
  function automatic logic [TIMER_WIDTH-1:0] sat_dec(input logic [TIMER_WIDTH-1:0] x);
    return (x == '0) ? '0 : x - TIMER_WIDTH'(1);
  endfunction

  logic                   hit, acc_ok, wr;
  logic [2:0]             off;
  logic [31:0]            rdata;

  logic [31:0]            out_q, out_d;
  logic [IN_WIDTH-1:0]    in_p0_q, in_p1_q, in_p2_q;
  logic [IN_WIDTH-1:0]    chg_q, chg_d, chg_set;
  logic                   en_q, en_d, ar_q, ar_d;
  logic [TIMER_WIDTH-1:0] load_q, load_d, cnt_q, cnt_d;
  logic                   exp_q, exp_d, exp_set;
  logic                   load_wr;

  assign hit    = (bus.Address >= BASE_ADDR) && (bus.Address <= BASE_ADDR + 32'h1C);
  assign acc_ok = hit && (bus.Address[1:0] == 2'b00);
  assign wr     = acc_ok && bus.MemWrite;
  assign off    = bus.Address[4:2];

  assign load_wr = wr && (off == OFF_LOAD);
  assign chg_set = in_p1_q ^ in_p2_q;

  always_comb begin
    out_d = out_q;
    en_d  = en_q;
    ar_d  = ar_q;
    load_d = load_q;
    chg_d = chg_q;
    exp_d = exp_q;
    if (wr && off == OFF_PORT_OUT) out_d = bus.WriteData;
    if (wr && off == OFF_CTRL) begin
      en_d = bus.WriteData[0];
      ar_d = bus.WriteData[1];
    end
    if (load_wr) load_d = bus.WriteData[TIMER_WIDTH-1:0];
    // Hardware set is OR-ed in after the W1C so it wins a same-edge collision.
    if (wr && off == OFF_IN_CHG) chg_d = chg_q & ~bus.WriteData[IN_WIDTH-1:0];
    chg_d = chg_d | chg_set;
    if (wr && off == OFF_STATUS && bus.WriteData[0]) exp_d = 1'b0;
    exp_d = exp_d | exp_set;
  end

  always_comb begin
    cnt_d   = cnt_q;
    exp_set = 1'b0;
    if (load_wr) begin
      cnt_d = bus.WriteData[TIMER_WIDTH-1:0];
    end else if (en_q) begin
      if (cnt_q == '0) begin
        if (ar_q) cnt_d = load_q;
      end else begin
        cnt_d   = sat_dec(cnt_q);
        exp_set = (cnt_q == TIMER_WIDTH'(1));
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (acc_ok && bus.MemRead) begin
      case (off)
        OFF_PORT_OUT: rdata = out_q;
        OFF_PORT_IN:  rdata = 32'(in_p1_q);
        OFF_IN_CHG:   rdata = 32'(chg_q);
        OFF_CTRL:     rdata = {30'b0, ar_q, en_q};
        OFF_LOAD:     rdata = 32'(load_q);
        OFF_COUNT:    rdata = 32'(cnt_q);
        OFF_STATUS:   rdata = {31'b0, exp_q};
        default:      rdata = '0;
      endcase
    end
  end

  // Register stage: PortIn passes p0 -> p1 (PORT_IN) -> p2 (previous) for change detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= '0;
      in_p0_q <= '0;
      in_p1_q <= '0;
      in_p2_q <= '0;
      chg_q   <= '0;
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      load_q  <= '0;
      cnt_q   <= '0;
      exp_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      in_p0_q <= PortIn;
      in_p1_q <= in_p0_q;
      in_p2_q <= in_p1_q;
      chg_q   <= chg_d;
      en_q    <= en_d;
      ar_q    <= ar_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
    end
  end

  assign bus.Hit      = hit;
  assign bus.ReadData = rdata;
  assign PortOut      = out_q;
  assign TimerIrq     = exp_q;

endmodule
